// File: rtl/psd_result_reader.sv
// rtl/psd_result_reader.sv - settle, average and hold the four filtered lock-in components for host readout
// One measurement per start: discard settle cycles, average 2^n valid samples, hold until the host takes it.
module psd_result_reader #(
  parameter int DATA_W = 36,
  parameter int AVG_W  = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [15:0]       i_settle,
  input  logic [AVG_W-1:0]  i_avg_log2,
  input  logic [DATA_W-1:0] i_A_X,
  input  logic [DATA_W-1:0] i_A_Y,
  input  logic [DATA_W-1:0] i_B_X,
  input  logic [DATA_W-1:0] i_B_Y,
  input  logic              i_IIR_valid,
  input  logic              i_rd_ready,
  output logic [DATA_W-1:0] o_A_X,
  output logic [DATA_W-1:0] o_A_Y,
  output logic [DATA_W-1:0] o_B_X,
  output logic [DATA_W-1:0] o_B_Y,
  output logic              o_rd_valid,
  output logic              o_busy
);

  // Seven guard bits cover the sum of 128 full-scale samples.
  localparam int ACC_W = DATA_W + 7;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] ACCUM  = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  logic [1:0]              state;
  logic [15:0]             settle_cnt;
  logic [AVG_W-1:0]        n_lat;
  logic [7:0]              sample_cnt;
  logic [8:0]              cnt_inc;
  logic                    last_sample;
  logic                    rd_valid;
  logic [DATA_W-1:0]       din [4];
  logic [DATA_W-1:0]       res [4];
  logic signed [ACC_W-1:0] acc [4];
  logic signed [ACC_W-1:0] sum [4];

  assign din[0] = i_A_X;
  assign din[1] = i_A_Y;
  assign din[2] = i_B_X;
  assign din[3] = i_B_Y;

  assign o_A_X      = res[0];
  assign o_A_Y      = res[1];
  assign o_B_X      = res[2];
  assign o_B_Y      = res[3];
  assign o_rd_valid = rd_valid;
  assign o_busy     = (state != IDLE);

  assign cnt_inc     = {1'b0, sample_cnt} + 9'd1;
  assign last_sample = (cnt_inc == (9'd1 << n_lat));

  // The final sample is folded in here so the result is registered on the edge that accepts it.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sum[i] = acc[i] + {{7{din[i][DATA_W-1]}}, din[i]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      n_lat      <= '0;
      sample_cnt <= '0;
      rd_valid   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        acc[i] <= '0;
        res[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            settle_cnt <= i_settle;
            n_lat      <= i_avg_log2;
            sample_cnt <= '0;
            for (int i = 0; i < 4; i++) begin
              acc[i] <= '0;
            end
            state <= (i_settle != 16'd0) ? SETTLE : ACCUM;
          end
        end
        SETTLE: begin
          if (settle_cnt <= 16'd1) begin
            settle_cnt <= '0;
            state      <= ACCUM;
          end else begin
            settle_cnt <= settle_cnt - 16'd1;
          end
        end
        ACCUM: begin
          if (i_IIR_valid) begin
            if (last_sample) begin
              for (int i = 0; i < 4; i++) begin
                res[i] <= DATA_W'(sum[i] >>> n_lat);
              end
              rd_valid <= 1'b1;
              state    <= HOLD;
            end else begin
              for (int i = 0; i < 4; i++) begin
                acc[i] <= sum[i];
              end
              sample_cnt <= cnt_inc[7:0];
            end
          end
        end
        HOLD: begin
          if (i_rd_ready) begin
            rd_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psd_result_reader.sv
// tb/tb_psd_result_reader.sv - randomized self-checking bench for psd_result_reader
// Stimulus index k is the value present at edge k, edge 0 being the start edge.
module tb_psd_result_reader;

  localparam int DW   = 36;
  localparam int AW   = 3;
  localparam int MAXE = 400;

  logic          clk = 1'b0;
  logic          i_rst_n, i_start, i_IIR_valid, i_rd_ready;
  logic [15:0]   i_settle;
  logic [AW-1:0] i_avg_log2;
  logic [DW-1:0] i_A_X, i_A_Y, i_B_X, i_B_Y;
  logic [DW-1:0] o_A_X, o_A_Y, o_B_X, o_B_Y;
  logic          o_rd_valid, o_busy;

  always #5 clk = ~clk;

  psd_result_reader #(.DATA_W(DW), .AVG_W(AW)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_settle(i_settle),
    .i_avg_log2(i_avg_log2), .i_A_X(i_A_X), .i_A_Y(i_A_Y), .i_B_X(i_B_X),
    .i_B_Y(i_B_Y), .i_IIR_valid(i_IIR_valid), .i_rd_ready(i_rd_ready),
    .o_A_X(o_A_X), .o_A_Y(o_A_Y), .o_B_X(o_B_X), .o_B_Y(o_B_Y),
    .o_rd_valid(o_rd_valid), .o_busy(o_busy)
  );

  logic                sv [0:MAXE];
  logic [3:0][DW-1:0]  sd [0:MAXE];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [3:0][DW-1:0] dut_outs();
    return {o_B_Y, o_B_X, o_A_Y, o_A_X};
  endfunction

  function automatic logic [DW-1:0] rand_dw();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  // Reference: skip the settle edges, average the first 2^n valid samples after them.
  function automatic void model(input int s, input int n, output int done,
                                output logic [3:0][DW-1:0] exp);
    longint sum [4];
    int taken;
    taken = 0;
    done  = -1;
    for (int c = 0; c < 4; c++) sum[c] = 0;
    for (int k = 1; k <= MAXE; k++) begin
      if (k > s && sv[k] && done < 0) begin
        for (int c = 0; c < 4; c++) sum[c] += longint'($signed(sd[k][c]));
        taken++;
        if (taken == (1 << n)) done = k;
      end
    end
    for (int c = 0; c < 4; c++) exp[c] = DW'(sum[c] >>> n);
  endfunction

  task automatic set_inputs(input int k);
    i_IIR_valid = sv[k];
    i_A_X = sd[k][0];
    i_A_Y = sd[k][1];
    i_B_X = sd[k][2];
    i_B_Y = sd[k][3];
  endtask

  task automatic drive_run(input int s, input int n, input int maxe,
                           output int seen, output logic [3:0][DW-1:0] got);
    seen = -1;
    got  = '0;
    i_settle   = 16'(s);
    i_avg_log2 = AW'(n);
    for (int k = 0; k <= maxe; k++) begin
      set_inputs(k);
      i_start = (k == 0);
      @(posedge clk); #1;
      i_start    = 1'b0;
      i_settle   = 16'($urandom());
      i_avg_log2 = AW'($urandom());
      if (o_rd_valid) begin
        seen = k;
        got  = dut_outs();
        break;
      end
    end
  endtask

  task automatic ack();
    i_rd_ready = 1'b1;
    @(posedge clk); #1;
    i_rd_ready = 1'b0;
  endtask

  task automatic fill_const(input logic [DW-1:0] v);
    for (int k = 0; k <= MAXE; k++) begin
      sv[k] = 1'b1;
      sd[k] = {v, v, v, v};
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_start = 1'b0; i_rd_ready = 1'b0; i_IIR_valid = 1'b0;
    i_settle = '0; i_avg_log2 = '0;
    i_A_X = '0; i_A_Y = '0; i_B_X = '0; i_B_Y = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (o_rd_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_rd_valid); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else n_pass++;
    n_checks++; if (dut_outs() !== '0) $display("FAIL reset_outs: got %h want 0", dut_outs()); else n_pass++;
    i_rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", o_busy); else n_pass++;
  endtask

  task automatic test_latency();
    int seen, done;
    logic [3:0][DW-1:0] got, exp;
    logic [DW-1:0] neg5;
    neg5 = DW'(-5);
    fill_const(neg5);
    model(0, 0, done, exp);
    drive_run(0, 0, 10, seen, got);
    n_checks++; if (seen !== 1) $display("FAIL latency_edge: got %0d want 1", seen); else n_pass++;
    n_checks++; if (got[0] !== neg5) $display("FAIL latency_ax: got %h want %h", got[0], neg5); else n_pass++;
    n_checks++; if (got !== exp) $display("FAIL latency_all: got %h want %h", got, exp); else n_pass++;
    n_checks++; if (o_busy !== 1'b1) $display("FAIL latency_busy: got %b want 1", o_busy); else n_pass++;
    ack();
    n_checks++; if (o_rd_valid !== 1'b0) $display("FAIL latency_ack_valid: got %b want 0", o_rd_valid); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL latency_ack_busy: got %b want 0", o_busy); else n_pass++;
  endtask

  task automatic test_settle_ramp();
    int seen, done;
    logic [3:0][DW-1:0] got, exp;
    for (int k = 0; k <= MAXE; k++) begin
      sv[k] = 1'b1;
      sd[k] = {DW'(k), rand_dw(), rand_dw(), rand_dw()};
    end
    model(10, 2, done, exp);
    drive_run(10, 2, 40, seen, got);
    n_checks++; if (seen !== done) $display("FAIL ramp_edge: got %0d want %0d", seen, done); else n_pass++;
    n_checks++; if (got[3] !== DW'(12)) $display("FAIL ramp_by: got %0d want 12", got[3]); else n_pass++;
    n_checks++; if (got !== exp) $display("FAIL ramp_all: got %h want %h", got, exp); else n_pass++;
    ack();
  endtask

  task automatic test_toggle();
    int seen, done;
    logic [3:0][DW-1:0] got, exp;
    for (int k = 0; k <= MAXE; k++) begin
      sv[k] = k[0];
      sd[k] = {rand_dw(), rand_dw(), ((k / 2) % 2 == 0) ? DW'(7) : DW'(-8), rand_dw()};
    end
    model(0, 3, done, exp);
    drive_run(0, 3, 40, seen, got);
    n_checks++; if (seen !== 15) $display("FAIL toggle_edge: got %0d want 15", seen); else n_pass++;
    n_checks++; if (got[1] !== DW'(-1)) $display("FAIL toggle_ay: got %h want %h", got[1], DW'(-1)); else n_pass++;
    n_checks++; if (got !== exp) $display("FAIL toggle_all: got %h want %h", got, exp); else n_pass++;
    ack();
  endtask

  task automatic test_max();
    int seen;
    logic [3:0][DW-1:0] got;
    logic [DW-1:0] maxv;
    maxv = {1'b0, {(DW-1){1'b1}}};
    fill_const(maxv);
    drive_run(0, 7, 200, seen, got);
    n_checks++; if (seen !== 128) $display("FAIL max_edge: got %0d want 128", seen); else n_pass++;
    n_checks++; if (got !== {maxv, maxv, maxv, maxv}) $display("FAIL max_outs: got %h want all %h", got, maxv); else n_pass++;
    ack();
  endtask

  task automatic test_hold();
    int seen, done;
    logic [3:0][DW-1:0] got, exp;
    for (int k = 0; k <= MAXE; k++) begin
      sv[k] = 1'b1;
      sd[k] = {rand_dw(), rand_dw(), rand_dw(), rand_dw()};
    end
    model(3, 2, done, exp);
    drive_run(3, 2, 40, seen, got);
    n_checks++; if (got !== exp || seen !== done) $display("FAIL hold_result: got %h@%0d want %h@%0d", got, seen, exp, done); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      i_start  = 1'($urandom());
      i_settle = 16'($urandom());
      set_inputs(i + 50);
      @(posedge clk); #1;
      n_checks++;
      if (o_rd_valid !== 1'b1 || o_busy !== 1'b1 || dut_outs() !== exp)
        $display("FAIL hold_stable: cycle %0d valid %b busy %b outs %h want 1 1 %h", i, o_rd_valid, o_busy, dut_outs(), exp);
      else n_pass++;
    end
    i_start = 1'b1;
    i_rd_ready = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_rd_ready = 1'b0;
    n_checks++; if (o_rd_valid !== 1'b0) $display("FAIL hold_drop_valid: got %b want 0", o_rd_valid); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL hold_start_ignored: busy %b want 0", o_busy); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (dut_outs() !== exp) $display("FAIL hold_retain: got %h want %h", dut_outs(), exp); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int seen;
    logic [3:0][DW-1:0] got;
    for (int k = 0; k <= MAXE; k++) begin
      sv[k] = 1'b1;
      sd[k] = {rand_dw(), rand_dw(), rand_dw(), rand_dw() | DW'(1)};
    end
    i_settle = '0;
    i_avg_log2 = AW'(3);
    for (int k = 0; k <= 3; k++) begin
      set_inputs(k);
      i_start = (k == 0);
      @(posedge clk); #1;
      i_start = 1'b0;
    end
    i_rst_n = 1'b0;
    #1;
    n_checks++; if (dut_outs() !== '0) $display("FAIL midrst_outs: got %h want 0", dut_outs()); else n_pass++;
    n_checks++; if (o_busy !== 1'b0 || o_rd_valid !== 1'b0) $display("FAIL midrst_flags: busy %b valid %b want 0 0", o_busy, o_rd_valid); else n_pass++;
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    fill_const(DW'(100));
    drive_run(0, 3, 40, seen, got);
    n_checks++; if (seen !== 8) $display("FAIL midrst_edge: got %0d want 8", seen); else n_pass++;
    n_checks++; if (got !== {DW'(100), DW'(100), DW'(100), DW'(100)}) $display("FAIL midrst_fresh: got %h want all 100", got); else n_pass++;
    ack();
  endtask

  task automatic test_back_to_back();
    int seen, done, s, n;
    logic [3:0][DW-1:0] got, exp;
    for (int it = 0; it < 10; it++) begin
      s = $urandom_range(0, 20);
      n = $urandom_range(0, 5);
      for (int k = 0; k <= MAXE; k++) begin
        sv[k] = ($urandom_range(0, 9) < 6);
        sd[k] = {rand_dw(), rand_dw(), rand_dw(), rand_dw()};
      end
      model(s, n, done, exp);
      drive_run(s, n, MAXE, seen, got);
      n_checks++; if (seen !== done) $display("FAIL rand_edge it%0d: got %0d want %0d", it, seen, done); else n_pass++;
      n_checks++; if (got !== exp) $display("FAIL rand_outs it%0d: got %h want %h", it, got, exp); else n_pass++;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      ack();
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_settle_ramp();
    test_toggle();
    test_max();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/psd_result_reader.md
PSD_RESULT_READER -- requirements
Module: psd_result_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 36, meaning the width of each filtered lock-in component.
REQ-002 SHALL have parameter AVG_W, default 3, meaning the width of the averaging exponent (maximum 2^7 = 128 samples).
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  asynchronous active-low reset.
REQ-005 i_start  input  1  request one measurement; sampled only in IDLE.
REQ-006 i_settle  input  16  filter settling cycles to discard before averaging; latched on accepted start.
REQ-007 i_avg_log2  input  AVG_W  average over 2^i_avg_log2 samples; latched on accepted start.
REQ-008 i_A_X, i_A_Y, i_B_X, i_B_Y  input  DATA_W each  signed filtered components from the PSD low-pass stage.
REQ-009 i_IIR_valid  input  1  filtered components valid this cycle.
REQ-010 i_rd_ready  input  1  host ready to take the result.
REQ-011 o_A_X, o_A_Y, o_B_X, o_B_Y  output  DATA_W each  signed averaged results.
REQ-012 o_rd_valid  output  1  result available; valid/ready handshake.
REQ-013 o_busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement the states IDLE, SETTLE, ACCUM and HOLD.
REQ-015 IDLE: on a clock edge with i_start=1, SHALL latch i_settle and i_avg_log2, clear all accumulators and the sample counter, and go to SETTLE if the latched settle value is nonzero, else to ACCUM.
REQ-016 SETTLE: SHALL occupy exactly the latched settle value in cycles, independent of i_IIR_valid, and then go to ACCUM; SHALL discard all input samples in this state.
REQ-017 ACCUM: on each edge with i_IIR_valid=1, SHALL add each sign-extended component to its own signed accumulator of DATA_W+7 bits and increment the sample counter.
REQ-018 ACCUM: SHALL ignore edges with i_IIR_valid=0 (no add, no count).
REQ-019 On the edge that accepts sample number 2^n (n = latched exponent), SHALL register each output as (accumulator + that sample) arithmetically right-shifted by n and truncated to DATA_W, SHALL set o_rd_valid=1 and SHALL go to HOLD.
REQ-020 Latency: for settle=0, n=0 and i_IIR_valid held high, o_rd_valid SHALL rise at the edge after the edge that accepts i_start.
REQ-021 HOLD: outputs and o_rd_valid SHALL remain stable until an edge with i_rd_ready=1; at that edge SHALL clear o_rd_valid and go to IDLE.
REQ-022 i_rd_ready SHALL have no effect while o_rd_valid=0.
REQ-023 i_start SHALL be ignored in SETTLE, ACCUM and HOLD; a start asserted in the same cycle as the HOLD handshake SHALL be ignored, and a new start SHALL be accepted no earlier than the following edge.
REQ-024 i_settle and i_avg_log2 changes after the accepted start SHALL NOT affect the measurement in progress.
REQ-025 The outputs SHALL retain the last result after the HOLD handshake until the next result is registered.
REQ-026 Accumulation SHALL NOT overflow for any DATA_W-bit inputs with n <= 7.

Reset
REQ-027 i_rst_n low SHALL immediately force IDLE, zero all accumulators and counters, o_A_X, o_A_Y, o_B_X, o_B_Y = 0, o_rd_valid = 0 and o_busy = 0, including when asserted mid-measurement.
REQ-028 After reset is released, the first start SHALL begin a fresh measurement with no residue from the aborted one.

Verification
REQ-029 settle=0, n=0, i_A_X=-5 constant, i_IIR_valid=1 -> o_A_X=-5 and o_rd_valid=1 one edge after the start edge.
REQ-030 settle=10, n=2, i_B_Y ramps 0,1,2,... once per cycle from the start edge with valid=1 -> the ramp values falling in the 10 settle cycles are discarded, the next 4 values are averaged, and the output is their sum >>> 2; the expected value is derived from the cycle-exact ramp alignment at the start edge.
REQ-031 n=3, valid toggling 1/0 with A_Y = +7,-8 alternating on valid cycles -> exactly 8 samples taken over 16 cycles, o_A_Y=-1 (arithmetic shift of -4).
REQ-032 n=7, all inputs = maximum positive value 2^35-1 -> outputs = 2^35-1, with no wrap.
REQ-033 Result held with i_rd_ready=0 for 20 cycles while i_start pulses -> outputs stable, start ignored; i_rd_ready=1 -> o_rd_valid drops next edge, IDLE reached.
REQ-034 Reset asserted during ACCUM after 3 of 8 samples, then a new start with constant input 100 -> result = 100, and all outputs read 0 during reset.
